sram_burst_ctrl: RTL

- Parametrised off-chip SRAM controller placed between the cache controller and the external asynchronous SRAM.
- Handles two kinds of access:
  - single-word writes, split into DQ_W-wide beats;
  - full cache-line reads, split into LINE_WORDS×BEATS beats.
- Timing per beat is programmable. Drives a stall handshake (readyOut) so the pipeline can freeze.

---
 rtl/sram_ctrl_pkg.sv | 22 ++
 rtl/sram_beat_timer.sv | 39 +++
 rtl/sram_burst_ctrl.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/sram_ctrl_pkg.sv
// Shared types and width helpers for the SRAM burst controller.
package sram_ctrl_pkg;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} state_t;
  typedef enum logic {OP_RD = 1'b0, OP_WR = 1'b1} op_t;

  localparam int unsigned BYTE_W = 8;

  function automatic int unsigned beats_of(int unsigned word_w, int unsigned dq_w);
    return word_w / dq_w;
  endfunction

  function automatic int unsigned line_width(int unsigned word_w, int unsigned line_words);
    return word_w * line_words;
  endfunction

  // Width needed to hold values 0..n-1, never below one bit.
  function automatic int unsigned cnt_width(int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sram_beat_timer.sv
// Beat sequencer: holds each beat for WAIT_STATES+1 cycles and counts n beats.
module sram_beat_timer
  import sram_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W       = 3,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             run,
  input  logic [CNT_W-1:0] n,
  output logic [CNT_W-1:0] beat,
  output logic             beat_last,
  output logic             done
);

  localparam int unsigned WAIT_W = cnt_width(WAIT_STATES + 1);

  logic [WAIT_W-1:0] wait_cnt;

  assign beat_last = run && (wait_cnt == WAIT_W'(WAIT_STATES));
  assign done      = beat_last && (beat == n - CNT_W'(1));

  always_ff @(posedge clk) begin
    if (rst || load) begin
      wait_cnt <= '0;
      beat     <= '0;
    end else if (run) begin
      if (beat_last) begin
        wait_cnt <= '0;
        beat     <= done ? '0 : beat + CNT_W'(1);
      end else begin
        wait_cnt <= wait_cnt + WAIT_W'(1);
      end
    end
  end

endmodule

// File: rtl/sram_burst_ctrl.sv
// Burst controller for an asynchronous SRAM: word writes and cache-line reads split into DQ_W beats.
// Define SRAM_BYTE_WRITE_EN to add the byteEnIn port and per-byte write masking.
module sram_burst_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned WORD_W      = 32,
  parameter int unsigned DQ_W        = 16,
  parameter int unsigned SRAM_ADDR_W = 18,
  parameter int unsigned LINE_WORDS  = 2,
  parameter int unsigned WAIT_STATES = 1,
  parameter int unsigned BASE_ADDR   = 1024
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         wrEnIn,
  input  logic                         rdEnIn,
  input  logic [ADDR_W-1:0]            addressIn,
  input  logic [WORD_W-1:0]            writeDataIn,
`ifdef SRAM_BYTE_WRITE_EN
  input  logic [WORD_W/8-1:0]          byteEnIn,
`endif
  output logic [WORD_W*LINE_WORDS-1:0] readDataOut,
  output logic                         readyOut,
  inout  wire  [DQ_W-1:0]              SRAM_DQInOut,
  output logic [SRAM_ADDR_W-1:0]       SRAM_ADDROut,
  output logic                         SRAM_UB_NOut,
  output logic                         SRAM_LB_NOut,
  output logic                         SRAM_WE_NOut,
  output logic                         SRAM_CE_NOut,
  output logic                         SRAM_OE_NOut
);

  localparam int unsigned BEATS  = beats_of(WORD_W, DQ_W);
  localparam int unsigned LINE_W = line_width(WORD_W, LINE_WORDS);
  localparam int unsigned N_RD   = LINE_WORDS * BEATS;
  localparam int unsigned CNT_W  = cnt_width(N_RD + 1);
  localparam logic [ADDR_W-1:0] LINE_MASK = ~(ADDR_W'(LINE_WORDS) - ADDR_W'(1));

  state_t               state, state_next;
  op_t                  op;
  logic [ADDR_W-1:0]    word_idx;
  logic [WORD_W-1:0]    wdata;
  logic [LINE_W-1:0]    line_buf, line_next;
  logic [CNT_W-1:0]     beat, n_beats;
  logic                 beat_last, done, request, we_n;
`ifdef SRAM_BYTE_WRITE_EN
  localparam int unsigned BPB = DQ_W / BYTE_W;
  logic [WORD_W/8-1:0]  be_q;
`endif

  assign request = wrEnIn | rdEnIn;
  assign n_beats = (op == OP_WR) ? CNT_W'(BEATS) : CNT_W'(N_RD);

  sram_beat_timer #(
    .CNT_W       (CNT_W),
    .WAIT_STATES (WAIT_STATES)
  ) u_timer (
    .clk       (clk),
    .rst       (rst),
    .load      (state == SETUP),
    .run       (state == ACCESS),
    .n         (n_beats),
    .beat      (beat),
    .beat_last (beat_last),
    .done      (done)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Request fields are latched on the IDLE->SETUP edge and held until the access ends.
  always_ff @(posedge clk) begin
    if (rst) begin
      op       <= OP_RD;
      word_idx <= '0;
      wdata    <= '0;
`ifdef SRAM_BYTE_WRITE_EN
      be_q     <= '0;
`endif
    end else if (state == IDLE && request) begin
      op       <= wrEnIn ? OP_WR : OP_RD;
      word_idx <= wrEnIn ? (addressIn - ADDR_W'(BASE_ADDR)) >> 2
                         : ((addressIn - ADDR_W'(BASE_ADDR)) >> 2) & LINE_MASK;
      wdata    <= writeDataIn;
`ifdef SRAM_BYTE_WRITE_EN
      be_q     <= byteEnIn;
`endif
    end
  end

  always_comb begin
    line_next = line_buf;
    line_next[beat*DQ_W +: DQ_W] = SRAM_DQInOut;
  end

  // The final beat is merged straight into readDataOut so the line is valid during DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      line_buf    <= '0;
      readDataOut <= '0;
    end else if (state == ACCESS && op == OP_RD && beat_last) begin
      line_buf <= line_next;
      if (done) readDataOut <= line_next;
    end
  end

  always_comb begin
    state_next   = state;
    readyOut     = 1'b1;
    SRAM_CE_NOut = 1'b1;
    SRAM_OE_NOut = 1'b1;
    SRAM_UB_NOut = 1'b0;
    SRAM_LB_NOut = 1'b0;
    we_n         = 1'b1;
    case (state)
      IDLE: begin
        readyOut = !request;
        if (request) state_next = SETUP;
      end
      SETUP: begin
        readyOut     = 1'b0;
        SRAM_CE_NOut = 1'b0;
        state_next   = ACCESS;
      end
      ACCESS: begin
        readyOut     = 1'b0;
        SRAM_CE_NOut = 1'b0;
        if (op == OP_RD) begin
          SRAM_OE_NOut = 1'b0;
        end else begin
          we_n = 1'b0;
`ifdef SRAM_BYTE_WRITE_EN
          SRAM_UB_NOut = !be_q[beat*BPB + BPB - 1];
          SRAM_LB_NOut = !be_q[beat*BPB];
          if (SRAM_UB_NOut && SRAM_LB_NOut) we_n = 1'b1;
`endif
        end
        if (done) state_next = DONE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
    // Reset drops an in-flight write strobe immediately rather than at the next edge.
    if (rst) begin
      readyOut = 1'b1;
      we_n     = 1'b1;
    end
  end

  assign SRAM_WE_NOut = we_n;
  assign SRAM_DQInOut = !we_n ? wdata[beat*DQ_W +: DQ_W] : 'z;
  assign SRAM_ADDROut = SRAM_ADDR_W'(word_idx * ADDR_W'(BEATS) + ADDR_W'(beat));

endmodule
